// File: rtl/regfile_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue_pkg
// Description : Shared register-file widths, the $zero address and the
//               writeback queue entry type used by the writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_queue_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of writeback entries with flush. Exposes the
//               raw storage, a per-slot valid mask and the read pointer so
//               the parent can run age-ordered searches over live entries.
// Ports       : clk_i, rst_i (async, active-high)
//               push_i/push_entry_i  enqueue (ignored when full or flushing)
//               pop_i                dequeue head (ignored when empty/flush)
//               flush_i              discard everything, highest priority
//               full_o/empty_o       occupancy flags
//               head_o               head entry, zero when empty
//               entries_o/valid_o    storage array and live-slot mask
//               rd_ptr_o             slot index of the oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
   import regfile_wb_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  wb_entry_t             push_entry_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   output wb_entry_t             head_o,
   output wb_entry_t [DEPTH-1:0] entries_o,
   output logic [DEPTH-1:0]      valid_o,
   output logic [PTR_W-1:0]      rd_ptr_o
);

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic                  do_push;
   logic                  do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         valid_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (do_push) begin
            wr_ptr_d          = wr_ptr_q + 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d          = rd_ptr_q + 1'b1;
            valid_d[rd_ptr_q] = 1'b0;
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   // Payload storage needs no reset: every consumer qualifies it with valid_q.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];
   assign entries_o = mem_q;
   assign valid_o   = valid_q;
   assign rd_ptr_o  = rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : Writer side of the register file's single write port.
//               Buffers long-latency writeback results and drains the head
//               entry whenever the write port is granted. Also exports a
//               pending-register scoreboard and two youngest-value lookups
//               for operand forwarding.
// Ports       : clk_i, rst_i (async, active-high), flush_i
//               in_valid_i/in_ready_o/in_addr_i/in_data_i  writeback request
//               write_grant_i                 regfile write port available
//               reg_write_o/write_addr_o/write_data_o    regfile write port
//               pending_o                     per-register queued flag
//               lookup_addr{1,2}_i/lookup_hit{1,2}_o/lookup_data{1,2}_o
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue
   import regfile_wb_queue_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = REG_DATA_W,
   parameter  int ADDR_W = REG_ADDR_W,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int NREG   = 1 << ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [ADDR_W-1:0] in_addr_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              write_grant_i,
   output logic              reg_write_o,
   output logic [ADDR_W-1:0] write_addr_o,
   output logic [DATA_W-1:0] write_data_o,
   output logic [NREG-1:0]   pending_o,
   input  logic [ADDR_W-1:0] lookup_addr1_i,
   output logic              lookup_hit1_o,
   output logic [DATA_W-1:0] lookup_data1_o,
   input  logic [ADDR_W-1:0] lookup_addr2_i,
   output logic              lookup_hit2_o,
   output logic [DATA_W-1:0] lookup_data2_o
);

   wb_entry_t             push_entry;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] entries;
   logic [DEPTH-1:0]      valid;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;

   // Ready is a pure function of occupancy; no full-and-pop bypass.
   assign in_ready_o = !full && !rst_i;

   // Writes to $zero complete the handshake but are never stored.
   assign push       = in_valid_i && in_ready_o && (in_addr_i != REG_ZERO) && !flush_i;
   assign push_entry = '{addr: in_addr_i, data: in_data_i};

   assign reg_write_o  = !empty && !flush_i;
   assign pop          = reg_write_o && write_grant_i;
   assign write_addr_o = head.addr;
   assign write_data_o = head.data;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (flush_i),
      .full_o       (full),
      .empty_o      (empty),
      .head_o       (head),
      .entries_o    (entries),
      .valid_o      (valid),
      .rd_ptr_o     (rd_ptr)
   );

   always_comb begin
      pending_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i]) begin
            pending_o[entries[i].addr] = 1'b1;
         end
      end
      pending_o[0] = 1'b0;
   end

   // Walk live entries oldest to youngest starting at the head slot, so the
   // last match seen is the youngest one. Result is {hit, data}.
   function automatic logic [DATA_W:0] f_lookup(
      input logic [ADDR_W-1:0]     a,
      input wb_entry_t [DEPTH-1:0] ents,
      input logic [DEPTH-1:0]      vld,
      input logic [PTR_W-1:0]      hd
   );
      logic [DATA_W:0]  r;
      logic [PTR_W-1:0] s;
      r = '0;
      for (int k = 0; k < DEPTH; k++) begin
         s = hd + PTR_W'(k);
         if (vld[s] && (a != REG_ZERO) && (ents[s].addr == a)) begin
            r = {1'b1, ents[s].data};
         end
      end
      return r;
   endfunction

   assign {lookup_hit1_o, lookup_data1_o} = f_lookup(lookup_addr1_i, entries, valid, rd_ptr);
   assign {lookup_hit2_o, lookup_data2_o} = f_lookup(lookup_addr2_i, entries, valid, rd_ptr);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_queue
// Description : Self-checking bench for regfile_wb_queue. A queue-based
//               reference model of the writeback FIFO is kept in the bench;
//               a negedge monitor compares every DUT output against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_addr = '0;
   logic [31:0] in_data = '0;
   logic        grant = 1'b0;
   logic        reg_write;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] pending;
   logic [4:0]  la1 = '0, la2 = '0;
   logic        hit1, hit2;
   logic [31:0] ld1, ld2;

   regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .in_addr_i      (in_addr),
      .in_data_i      (in_data),
      .write_grant_i  (grant),
      .reg_write_o    (reg_write),
      .write_addr_o   (write_addr),
      .write_data_o   (write_data),
      .pending_o      (pending),
      .lookup_addr1_i (la1),
      .lookup_hit1_o  (hit1),
      .lookup_data1_o (ld1),
      .lookup_addr2_i (la2),
      .lookup_hit2_o  (hit2),
      .lookup_data2_o (ld2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];          // reference queue: front = oldest = next write
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] model_lookup(input logic [4:0] a);
      logic [32:0] r;
      r = '0;
      foreach (mq[i]) begin
         if (a != 5'd0 && mq[i].a == a) r = {1'b1, mq[i].d};
      end
      return r;
   endfunction

   // Monitor: compare at negedge, then advance the model by what the coming
   // posedge will do given the (stable) inputs.
   always @(negedge clk) begin
      logic [31:0] exp_pend;
      logic [32:0] l1, l2;
      logic        exp_ready, exp_wr;
      if (rst) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_reg_write", reg_write, 0);
         chk("rst_pending", pending, 0);
         chk("rst_hit1", hit1, 0);
         chk("rst_hit2", hit2, 0);
         mq.delete();
      end else begin
         exp_ready = (mq.size() < DEPTH);
         exp_wr    = (mq.size() != 0) && !flush;
         chk("in_ready", in_ready, exp_ready);
         chk("reg_write", reg_write, exp_wr);
         if (mq.size() != 0) begin
            chk("write_addr", write_addr, mq[0].a);
            chk("write_data", write_data, mq[0].d);
         end else begin
            chk("write_addr_empty", write_addr, 0);
            chk("write_data_empty", write_data, 0);
         end
         exp_pend = '0;
         foreach (mq[i]) exp_pend[mq[i].a] = 1'b1;
         exp_pend[0] = 1'b0;
         chk("pending", pending, exp_pend);
         l1 = model_lookup(la1);
         l2 = model_lookup(la2);
         chk("lookup1", {hit1, ld1}, l1);
         chk("lookup2", {hit2, ld2}, l2);
         if (flush) begin
            mq.delete();
         end else begin
            if (exp_wr && grant) void'(mq.pop_front());
            if (in_valid && exp_ready && in_addr != 5'd0) mq.push_back('{a: in_addr, d: in_data});
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      cyc(1);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("ready_after_reset", in_ready, 1);

      // 1: single write, granted immediately
      grant = 1'b1;
      push(5'd5, 32'hDEADBEEF);
      cyc(3);

      // 2: $zero write accepted but dropped
      push(5'd0, 32'h1234);
      cyc(2);

      // 3: fill with grant off, hold a fifth request, then drain in order
      grant = 1'b0;
      for (int i = 1; i <= 4; i++) push(5'(i), 32'(9 + i));
      in_valid = 1'b1; in_addr = 5'd6; in_data = 32'd14;
      cyc(3);
      grant = 1'b1;
      cyc(2);
      in_valid = 1'b0;
      cyc(6);

      // 4: youngest-match forwarding on register 7
      grant = 1'b0;
      la1 = 5'd7;
      push(5'd7, 32'h11);
      push(5'd7, 32'h22);
      cyc(2);
      grant = 1'b1; cyc(1);
      grant = 1'b0; cyc(1);
      grant = 1'b1; cyc(2);

      // 5: flush beats a same-cycle push and pop
      grant = 1'b0;
      push(5'd3, 32'h33);
      push(5'd4, 32'h44);
      flush = 1'b1; grant = 1'b1;
      in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h55;
      cyc(1);
      flush = 1'b0; in_valid = 1'b0;
      cyc(3);

      // 6: asynchronous reset mid-cycle with entries queued
      grant = 1'b0;
      push(5'd10, 32'hA);
      push(5'd11, 32'hB);
      push(5'd12, 32'hC);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_reg_write", reg_write, 0);
      chk("async_rst_pending", pending, 0);
      chk("async_rst_in_ready", in_ready, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("ready_after_release", in_ready, 1);
      grant = 1'b1;
      cyc(4);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         in_valid = ($urandom_range(0, 1) == 1);
         in_addr  = 5'($urandom_range(0, 7));
         in_data  = $urandom;
         grant    = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 29) == 0);
         la1      = 5'($urandom_range(0, 7));
         la2      = 5'($urandom_range(0, 7));
         cyc(1);
      end
      in_valid = 1'b0; flush = 1'b0; grant = 1'b1;
      cyc(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
